// File: rtl/ball_centroid_tracker.sv
// Per-frame centroid of pixels inside a fixed orange colour box.
// Two restoring dividers run in parallel at frame end to turn the X/Y sums into a mean.
module ball_centroid_tracker #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int R_MIN      = 200,
    parameter int G_MAX      = 100,
    parameter int B_MAX      = 100,
    parameter int MIN_PIXELS = 16
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [7:0]  iRed,
    input  logic [7:0]  iGreen,
    input  logic [7:0]  iBlue,
    input  logic        iDVAL,
    input  logic [12:0] iH_Cont,
    input  logic [12:0] iV_Cont,
    input  logic        iVS,
    output logic [9:0]  oX,
    output logic [8:0]  oY,
    output logic [18:0] oCount,
    output logic        oFound,
    output logic        oValid
);
    localparam logic [7:0]  R_MIN_L = 8'(R_MIN);
    localparam logic [7:0]  G_MAX_L = 8'(G_MAX);
    localparam logic [7:0]  B_MAX_L = 8'(B_MAX);
    localparam logic [12:0] H_ACT_L = 13'(H_ACTIVE);
    localparam logic [12:0] V_ACT_L = 13'(V_ACTIVE);
    localparam logic [18:0] MIN_L   = 19'(MIN_PIXELS);

    typedef enum logic [1:0] {ACCUM, DIV, PUBLISH_HIT, PUBLISH_MISS} state_t;

    state_t      state_q, state_d;
    logic        vs_q, vs_d, armed_q, armed_d;
    logic [28:0] sum_x_q, sum_x_d;
    logic [27:0] sum_y_q, sum_y_d;
    logic [18:0] cnt_q, cnt_d;
    logic [28:0] dx_q, dx_d, dy_q, dy_d, qx_q, qx_d, qy_q, qy_d;
    logic [18:0] dv_q, dv_d, rx_q, rx_d, ry_q, ry_d;
    logic [4:0]  bit_q, bit_d;
    logic [9:0]  ox_q, ox_d;
    logic [8:0]  oy_q, oy_d;
    logic [18:0] ocount_q, ocount_d;
    logic        ofound_q, ofound_d, ovalid_q, ovalid_d;

    logic        qual, vs_fall;
    logic [28:0] add_x;
    logic [27:0] add_y;
    logic [18:0] add_c;
    logic [19:0] step_x, step_y;

    // One restoring step: returns {quotient bit, new remainder}.
    function automatic logic [19:0] div_step(input logic [18:0] rem, input logic din,
                                             input logic [18:0] dvs);
        logic [19:0] sh;
        sh = {rem, din};
        if (sh >= {1'b0, dvs}) div_step = {1'b1, 19'(sh - {1'b0, dvs})};
        else                   div_step = {1'b0, sh[18:0]};
    endfunction

    always_comb begin
        qual = iDVAL && (iRed >= R_MIN_L) && (iGreen <= G_MAX_L) && (iBlue <= B_MAX_L)
               && (iH_Cont < H_ACT_L) && (iV_Cont < V_ACT_L);
        add_x = qual ? {19'd0, iH_Cont[9:0]} : 29'd0;
        add_y = qual ? {19'd0, iV_Cont[8:0]} : 28'd0;
        add_c = qual ? 19'd1 : 19'd0;
        // A sync held low through reset must go high once before its fall counts.
        vs_fall = vs_q && !iVS && armed_q;
        step_x  = div_step(rx_q, dx_q[28], dv_q);
        step_y  = div_step(ry_q, dy_q[28], dv_q);

        state_d  = state_q;
        vs_d     = iVS;
        armed_d  = armed_q | iVS;
        sum_x_d  = sum_x_q + add_x;
        sum_y_d  = sum_y_q + add_y;
        cnt_d    = cnt_q + add_c;
        dx_d     = dx_q;
        dy_d     = dy_q;
        qx_d     = qx_q;
        qy_d     = qy_q;
        dv_d     = dv_q;
        rx_d     = rx_q;
        ry_d     = ry_q;
        bit_d    = bit_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        ocount_d = ocount_q;
        ofound_d = ofound_q;
        ovalid_d = 1'b0;

        case (state_q)
            ACCUM: begin
                if (vs_fall) begin
                    dx_d    = sum_x_q;
                    dy_d    = {1'b0, sum_y_q};
                    dv_d    = cnt_q;
                    rx_d    = '0;
                    ry_d    = '0;
                    qx_d    = '0;
                    qy_d    = '0;
                    sum_x_d = add_x;
                    sum_y_d = add_y;
                    cnt_d   = add_c;
                    if (cnt_q < MIN_L) begin
                        state_d  = PUBLISH_MISS;
                        ocount_d = cnt_q;
                        ofound_d = 1'b0;
                        ovalid_d = 1'b1;
                    end else begin
                        state_d = DIV;
                        bit_d   = 5'd28;
                    end
                end
            end
            DIV: begin
                dx_d = {dx_q[27:0], 1'b0};
                dy_d = {dy_q[27:0], 1'b0};
                qx_d = {qx_q[27:0], step_x[19]};
                qy_d = {qy_q[27:0], step_y[19]};
                rx_d = step_x[18:0];
                ry_d = step_y[18:0];
                if (bit_q == 5'd0) begin
                    state_d  = PUBLISH_HIT;
                    ox_d     = qx_d[9:0];
                    oy_d     = qy_d[8:0];
                    ocount_d = dv_q;
                    ofound_d = 1'b1;
                    ovalid_d = 1'b1;
                end else begin
                    bit_d = bit_q - 5'd1;
                end
            end
            PUBLISH_HIT, PUBLISH_MISS: state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= ACCUM;
            vs_q     <= 1'b1;
            armed_q  <= 1'b0;
            sum_x_q  <= '0;
            sum_y_q  <= '0;
            cnt_q    <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            qx_q     <= '0;
            qy_q     <= '0;
            dv_q     <= '0;
            rx_q     <= '0;
            ry_q     <= '0;
            bit_q    <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            ocount_q <= '0;
            ofound_q <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            vs_q     <= vs_d;
            armed_q  <= armed_d;
            sum_x_q  <= sum_x_d;
            sum_y_q  <= sum_y_d;
            cnt_q    <= cnt_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            qx_q     <= qx_d;
            qy_q     <= qy_d;
            dv_q     <= dv_d;
            rx_q     <= rx_d;
            ry_q     <= ry_d;
            bit_q    <= bit_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            ocount_q <= ocount_d;
            ofound_q <= ofound_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign oX     = ox_q;
    assign oY     = oy_q;
    assign oCount = ocount_q;
    assign oFound = ofound_q;
    assign oValid = ovalid_q;
endmodule
